correlation_scheduler: RTL and testbench
========================================

Name: correlation_scheduler

Overview:
- Sequences one shared correlator across NUM_TEMPLATES stored audio templates, one template at a time.
- For each template, launches a correlation at that template's bank base address and waits for the result.
- Keeps the running best score across templates, then raises transmit_ready with the winning template, score and lag.
- Sits between the top-level capture state machine and the correlator. This replaces one correlator instance per template.

Parameters:
- NUM_TEMPLATES, 4: number of templates in the bank; must be 2..16.
- TEMPLATE_LEN, 2000: samples per template; template k base = k*TEMPLATE_LEN.
- ADDR_W, 14: width of bank base address; must hold (NUM_TEMPLATES-1)*TEMPLATE_LEN.
- TIMEOUT_CYCLES, 8192: cycles allowed in WAIT before a template is abandoned.
- MIN_SCORE, 15'd64: minimum best_score required to assert match_found.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE or DONE.
- transmit_ack  in  1  consumer has read the result; DONE -> IDLE.
- corr_done  in  1  correlator finished; sampled only in WAIT.
- corr_result  in  36  raw max correlation; valid when corr_done=1.
- corr_max_index  in  12  lag of that maximum; valid when corr_done=1.
- corr_start  out  1  one-cycle launch pulse to the correlator.
- corr_base  out  ADDR_W  template base address; held stable from LAUNCH through WAIT.
- busy  out  1  high in LAUNCH, WAIT and COMPARE.
- transmit_ready  out  1  high in DONE only.
- best_template  out  4  index of the winning template.
- best_score  out  15  corr_result[35:21] of the winner.
- best_index  out  12  corr_max_index of the winner.
- match_found  out  1  best_score >= MIN_SCORE; valid while transmit_ready=1.
- timeout_flag  out  1  at least one template timed out this run.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE; all outputs 0, including corr_base, best_* and flags; idx=0; watchdog=0.
- Reset mid-run abandons the run immediately. No corr_start is issued until the next start.
- States: IDLE, LAUNCH, WAIT, COMPARE, DONE.
- IDLE:
  - start=1 -> LAUNCH; clear idx, best_*, timeout_flag and match_found.
  - transmit_ack is ignored.
- LAUNCH (1 cycle):
  - corr_start=1; corr_base=idx*TEMPLATE_LEN, registered so it is glitch-free; watchdog=0.
  - Next state: WAIT.
- WAIT:
  - watchdog increments every cycle.
  - corr_done=1 -> latch score=corr_result[35:21] and lag=corr_max_index -> COMPARE.
  - watchdog reaching TIMEOUT_CYCLES-1 with no corr_done -> score=0, lag=0, timeout_flag=1 -> COMPARE.
  - If corr_done and timeout occur in the same cycle, corr_done wins.
- COMPARE (1 cycle):
  - Update best if idx==0 or score > best_score (strictly greater). Ties keep the lower template index.
  - If idx==NUM_TEMPLATES-1 -> DONE; else idx+1 -> LAUNCH.
- DONE:
  - transmit_ready=1; best_*, match_found and timeout_flag held stable.
  - transmit_ack=1 -> IDLE; best_* keep their values, transmit_ready drops.
  - start=1 -> new run (same as start from IDLE). start wins over a simultaneous transmit_ack.
- start during busy is ignored; no queuing.
- corr_done outside WAIT is ignored.
- Latency, with the correlator answering in D cycles after corr_start:
  - per template: 1 (LAUNCH) + D (WAIT) + 1 (COMPARE);
  - start to transmit_ready: 1 + NUM_TEMPLATES*(D+2) cycles.
- match_found is computed in the COMPARE cycle that enters DONE, and is 0 outside DONE.

Test Plan:
- Four templates, correlator with D=5; scores 10, 300, 120, 299 (corr_result=score<<21, lags 7, 42, 3, 9):
  - corr_base values 0, 2000, 4000, 6000, one corr_start each;
  - transmit_ready at cycle 1+4*7=29 after start;
  - best_template=1, best_score=300, best_index=42, match_found=1.
- Scores 50, 50, 20, 50:
  - best_template=0, best_score=50 (tie keeps lower index);
  - match_found=0 because 50 < 64.
- Template 2 never returns corr_done:
  - after 8192 WAIT cycles, timeout_flag=1 and template 2 scores 0;
  - run completes with 4 corr_start pulses and best taken from templates 0, 1 and 3.
- start pulsed during WAIT of template 1:
  - ignored; the run proceeds unchanged and exactly 4 corr_start pulses occur.
- reset_n low during WAIT of template 2:
  - outputs go to 0 asynchronously and state is IDLE;
  - no corr_start until a new start;
  - a fresh run then produces the correct best result.
- In DONE, start and transmit_ack asserted in the same cycle:
  - transmit_ready drops, busy=1 and corr_start pulses with corr_base=0 on the next cycle.

Source files
------------

// File: rtl/correlation_scheduler.sv
// Time-multiplexes one shared correlator across a bank of stored templates,
// keeping the best score/lag seen and presenting the winner to the transmitter.
module correlation_scheduler #(
  parameter int          NUM_TEMPLATES  = 4,
  parameter int          TEMPLATE_LEN   = 2000,
  parameter int          ADDR_W         = 14,
  parameter int          TIMEOUT_CYCLES = 8192,
  parameter logic [14:0] MIN_SCORE      = 15'd64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              transmit_ack,
  input  logic              corr_done,
  input  logic [35:0]       corr_result,
  input  logic [11:0]       corr_max_index,
  output logic              corr_start,
  output logic [ADDR_W-1:0] corr_base,
  output logic              busy,
  output logic              transmit_ready,
  output logic [3:0]        best_template,
  output logic [14:0]       best_score,
  output logic [11:0]       best_index,
  output logic              match_found,
  output logic              timeout_flag
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int         WD_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [3:0] LAST_IDX = 4'(NUM_TEMPLATES - 1);

  logic [2:0]        state_r, state_next_s;
  logic [3:0]        idx_r, idx_next_s;
  logic [WD_W-1:0]   watchdog_r;
  logic [14:0]       score_r;
  logic [11:0]       lag_r;
  logic              begin_run_s;
  logic              wd_expired_s;
  logic              update_s;
  logic [14:0]       cand_score_s;

  logic              corr_start_r, busy_r, transmit_ready_r, match_found_r, timeout_flag_r;
  logic [ADDR_W-1:0] corr_base_r;
  logic [3:0]        best_template_r;
  logic [14:0]       best_score_r;
  logic [11:0]       best_index_r;

  assign wd_expired_s = (watchdog_r == WD_W'(TIMEOUT_CYCLES - 1));
  // Template 0 always seeds the best; afterwards only a strictly higher score wins.
  assign update_s     = (idx_r == 4'd0) || (score_r > best_score_r);
  assign cand_score_s = update_s ? score_r : best_score_r;

  // Next-state and template index selection.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    begin_run_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_LAUNCH;
          idx_next_s   = 4'd0;
          begin_run_s  = 1'b1;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LAUNCH: state_next_s = S_WAIT;
      S_WAIT: begin
        if (corr_done || wd_expired_s) begin
          state_next_s = S_COMPARE;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_COMPARE: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_LAUNCH;
          idx_next_s   = idx_r + 4'd1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_next_s = S_LAUNCH;
          idx_next_s   = 4'd0;
          begin_run_s  = 1'b1;
        end else if (transmit_ack) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_DONE;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, index and watchdog registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      idx_r      <= 4'd0;
      watchdog_r <= '0;
    end else begin
      state_r    <= state_next_s;
      idx_r      <= idx_next_s;
      watchdog_r <= (state_r == S_WAIT) ? watchdog_r + WD_W'(1) : '0;
    end
  end

  // Latch the per-template score and lag, or zeros when the correlator never answers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_r        <= 15'd0;
      lag_r          <= 12'd0;
      timeout_flag_r <= 1'b0;
    end else if (begin_run_s) begin
      timeout_flag_r <= 1'b0;
    end else if (state_r == S_WAIT) begin
      if (corr_done) begin
        score_r <= corr_result[35:21];
        lag_r   <= corr_max_index;
      end else if (wd_expired_s) begin
        score_r        <= 15'd0;
        lag_r          <= 12'd0;
        timeout_flag_r <= 1'b1;
      end
    end
  end

  // Running best across templates and the final threshold decision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      best_template_r <= 4'd0;
      best_score_r    <= 15'd0;
      best_index_r    <= 12'd0;
      match_found_r   <= 1'b0;
    end else if (begin_run_s) begin
      best_template_r <= 4'd0;
      best_score_r    <= 15'd0;
      best_index_r    <= 12'd0;
      match_found_r   <= 1'b0;
    end else if (state_r == S_COMPARE) begin
      if (update_s) begin
        best_template_r <= idx_r;
        best_score_r    <= score_r;
        best_index_r    <= lag_r;
      end
      match_found_r <= (idx_r == LAST_IDX) && (cand_score_s >= MIN_SCORE);
    end else if (state_next_s != S_DONE) begin
      match_found_r <= 1'b0;
    end
  end

  // Handshake outputs are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      corr_start_r     <= 1'b0;
      busy_r           <= 1'b0;
      transmit_ready_r <= 1'b0;
      corr_base_r      <= '0;
    end else begin
      corr_start_r     <= (state_next_s == S_LAUNCH);
      busy_r           <= (state_next_s == S_LAUNCH) || (state_next_s == S_WAIT) ||
                          (state_next_s == S_COMPARE);
      transmit_ready_r <= (state_next_s == S_DONE);
      if (state_next_s == S_LAUNCH) begin
        corr_base_r <= ADDR_W'(32'(idx_next_s) * TEMPLATE_LEN);
      end
    end
  end

  assign corr_start     = corr_start_r;
  assign corr_base      = corr_base_r;
  assign busy           = busy_r;
  assign transmit_ready = transmit_ready_r;
  assign best_template  = best_template_r;
  assign best_score     = best_score_r;
  assign best_index     = best_index_r;
  assign match_found    = match_found_r;
  assign timeout_flag   = timeout_flag_r;

endmodule

// File: tb/tb_correlation_scheduler.sv
// Directed bench for correlation_scheduler with a behavioural correlator answering D=5 cycles after launch.
module tb_correlation_scheduler;

  localparam int D = 5;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        transmit_ack = 1'b0;
  logic        corr_done = 1'b0;
  logic [35:0] corr_result = 36'd0;
  logic [11:0] corr_max_index = 12'd0;
  logic        corr_start;
  logic [13:0] corr_base;
  logic        busy, transmit_ready, match_found, timeout_flag;
  logic [3:0]  best_template;
  logic [14:0] best_score;
  logic [11:0] best_index;

  int n_checks = 0;
  int n_fails  = 0;

  logic [14:0] cfg_score [4];
  logic [11:0] cfg_lag   [4];
  bit          cfg_silent[4];

  int          pulse_total = 0;
  logic [13:0] bases[64];
  int          cnt_m = 0;
  int          tidx_m = 0;

  correlation_scheduler dut (
    .clk(clk), .reset_n(reset_n), .start(start), .transmit_ack(transmit_ack),
    .corr_done(corr_done), .corr_result(corr_result), .corr_max_index(corr_max_index),
    .corr_start(corr_start), .corr_base(corr_base), .busy(busy),
    .transmit_ready(transmit_ready), .best_template(best_template), .best_score(best_score),
    .best_index(best_index), .match_found(match_found), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  // Behavioural correlator: corr_done lands in the D-th WAIT cycle after the launch pulse.
  always @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_m = 0;
      corr_done = 1'b0;
    end else if (corr_start) begin
      bases[pulse_total % 64] = corr_base;
      pulse_total = pulse_total + 1;
      tidx_m = int'(corr_base) / 2000;
      cnt_m = cfg_silent[tidx_m % 4] ? 0 : D;
      corr_done = 1'b0;
    end else if (cnt_m > 0) begin
      cnt_m = cnt_m - 1;
      corr_done = (cnt_m == 0);
      corr_result = {cfg_score[tidx_m % 4], 21'd0};
      corr_max_index = cfg_lag[tidx_m % 4];
    end else begin
      corr_done = 1'b0;
    end
  end

  task automatic set_cfg(input logic [14:0] s0, s1, s2, s3, input logic [11:0] l0, l1, l2, l3,
                         input int silent_idx);
    cfg_score[0] = s0; cfg_score[1] = s1; cfg_score[2] = s2; cfg_score[3] = s3;
    cfg_lag[0] = l0; cfg_lag[1] = l1; cfg_lag[2] = l2; cfg_lag[3] = l3;
    for (int i = 0; i < 4; i++) cfg_silent[i] = (i == silent_idx);
  endtask

  // Pulses start, optionally re-pulses it after edge 'inject', and counts edges until transmit_ready.
  task automatic run(input int inject, output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #1;
      edges++;
      start = (edges == inject);
      if (transmit_ready) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    transmit_ack = 1'b1;
    @(posedge clk);
    #1;
    transmit_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, corr_start, transmit_ready, match_found, timeout_flag, corr_base, best_template,
         best_score, best_index} !== 61'd0) begin
      n_fails++;
      $display("FAIL reset_outputs: got busy=%0b cs=%0b tr=%0b base=%0d score=%0d",
               busy, corr_start, transmit_ready, corr_base, best_score);
    end
    @(negedge clk);
    reset_n = 1'b1;
    do_ack();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, transmit_ready, corr_start} !== 3'b000) begin
      n_fails++;
      $display("FAIL idle_ack_ignored: got busy=%0b tr=%0b cs=%0b expected 0 0 0",
               busy, transmit_ready, corr_start);
    end
  endtask

  task automatic test_basic_run();
    int edges; bit ok; int p0;
    logic [13:0] exp_base;
    set_cfg(15'd10, 15'd300, 15'd120, 15'd299, 12'd7, 12'd42, 12'd3, 12'd9, -1);
    p0 = pulse_total;
    run(0, edges, ok);
    n_checks++;
    if (!ok || edges !== 29) begin
      n_fails++;
      $display("FAIL basic_latency: got ok=%0b edges=%0d expected edges=29", ok, edges);
    end
    n_checks++;
    if (pulse_total - p0 !== 4) begin
      n_fails++;
      $display("FAIL basic_pulses: got %0d expected 4", pulse_total - p0);
    end
    for (int k = 0; k < 4; k++) begin
      exp_base = 14'(k * 2000);
      n_checks++;
      if (bases[(p0 + k) % 64] !== exp_base) begin
        n_fails++;
        $display("FAIL basic_base%0d: got %0d expected %0d", k, bases[(p0 + k) % 64], exp_base);
      end
    end
    n_checks++;
    if ({best_template, best_score, best_index, match_found, timeout_flag, busy} !==
        {4'd1, 15'd300, 12'd42, 1'b1, 1'b0, 1'b0}) begin
      n_fails++;
      $display("FAIL basic_best: got t=%0d s=%0d i=%0d m=%0b to=%0b busy=%0b expected 1 300 42 1 0 0",
               best_template, best_score, best_index, match_found, timeout_flag, busy);
    end
    do_ack();
    n_checks++;
    if ({transmit_ready, match_found, best_template, best_score, best_index} !==
        {1'b0, 1'b0, 4'd1, 15'd300, 12'd42}) begin
      n_fails++;
      $display("FAIL ack_hold: got tr=%0b m=%0b t=%0d s=%0d i=%0d expected 0 0 1 300 42",
               transmit_ready, match_found, best_template, best_score, best_index);
    end
  endtask

  task automatic test_tie();
    int edges; bit ok;
    set_cfg(15'd50, 15'd50, 15'd20, 15'd50, 12'd5, 12'd6, 12'd7, 12'd8, -1);
    run(0, edges, ok);
    n_checks++;
    if (!ok || {best_template, best_score, best_index, match_found} !==
        {4'd0, 15'd50, 12'd5, 1'b0}) begin
      n_fails++;
      $display("FAIL tie_low_index: got ok=%0b t=%0d s=%0d i=%0d m=%0b expected 0 50 5 0",
               ok, best_template, best_score, best_index, match_found);
    end
    do_ack();
  endtask

  task automatic test_timeout();
    int edges; bit ok; int p0;
    set_cfg(15'd100, 15'd70, 15'd500, 15'd90, 12'd1, 12'd2, 12'd3, 12'd4, 2);
    p0 = pulse_total;
    run(0, edges, ok);
    n_checks++;
    if (!ok || edges !== 8216 || pulse_total - p0 !== 4) begin
      n_fails++;
      $display("FAIL timeout_latency: got ok=%0b edges=%0d pulses=%0d expected 8216 4",
               ok, edges, pulse_total - p0);
    end
    n_checks++;
    if ({timeout_flag, best_template, best_score, best_index, match_found} !==
        {1'b1, 4'd0, 15'd100, 12'd1, 1'b1}) begin
      n_fails++;
      $display("FAIL timeout_best: got to=%0b t=%0d s=%0d i=%0d m=%0b expected 1 0 100 1 1",
               timeout_flag, best_template, best_score, best_index, match_found);
    end
    do_ack();
  endtask

  task automatic test_start_ignored();
    int edges; bit ok; int p0;
    set_cfg(15'd10, 15'd300, 15'd120, 15'd299, 12'd7, 12'd42, 12'd3, 12'd9, -1);
    p0 = pulse_total;
    run(10, edges, ok);
    n_checks++;
    if (!ok || edges !== 29 || pulse_total - p0 !== 4 || timeout_flag !== 1'b0 ||
        {best_template, best_score, best_index} !== {4'd1, 15'd300, 12'd42}) begin
      n_fails++;
      $display("FAIL start_in_wait: got edges=%0d pulses=%0d to=%0b t=%0d s=%0d expected 29 4 0 1 300",
               edges, pulse_total - p0, timeout_flag, best_template, best_score);
    end
    do_ack();
  endtask

  task automatic test_reset_mid_run();
    int edges; bit ok; bit found; int p0;
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (busy && !corr_start && corr_base == 14'd4000) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fails++;
      $display("FAIL reach_wait2: got no WAIT of template 2 within 60 cycles");
    end
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, corr_start, transmit_ready, match_found, timeout_flag, corr_base, best_template,
         best_score, best_index} !== 61'd0) begin
      n_fails++;
      $display("FAIL async_reset: got busy=%0b base=%0d t=%0d s=%0d expected all 0",
               busy, corr_base, best_template, best_score);
    end
    p0 = pulse_total;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (pulse_total !== p0 || busy !== 1'b0) begin
      n_fails++;
      $display("FAIL no_launch_after_reset: got pulses=%0d busy=%0b expected 0 0",
               pulse_total - p0, busy);
    end
    run(0, edges, ok);
    n_checks++;
    if (!ok || edges !== 29 || {best_template, best_score, best_index, match_found} !==
        {4'd1, 15'd300, 12'd42, 1'b1}) begin
      n_fails++;
      $display("FAIL fresh_run: got edges=%0d t=%0d s=%0d i=%0d expected 29 1 300 42",
               edges, best_template, best_score, best_index);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    @(negedge clk);
    start = 1'b1;
    transmit_ack = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    transmit_ack = 1'b0;
    n_checks++;
    if ({transmit_ready, busy, corr_start, corr_base, best_score} !==
        {1'b0, 1'b1, 1'b1, 14'd0, 15'd0}) begin
      n_fails++;
      $display("FAIL start_over_ack: got tr=%0b busy=%0b cs=%0b base=%0d s=%0d expected 0 1 1 0 0",
               transmit_ready, busy, corr_start, corr_base, best_score);
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (transmit_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || {best_template, best_score, best_index} !== {4'd1, 15'd300, 12'd42}) begin
      n_fails++;
      $display("FAIL b2b_result: got ok=%0b t=%0d s=%0d i=%0d expected 1 1 300 42",
               ok, best_template, best_score, best_index);
    end
    do_ack();
  endtask

  initial begin
    set_cfg(15'd0, 15'd0, 15'd0, 15'd0, 12'd0, 12'd0, 12'd0, 12'd0, -1);
    test_reset();
    test_basic_run();
    test_tie();
    test_timeout();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
